// File: rtl/fsm_programmable.sv
// Table-driven Moore FSM: each state owns a flop-held entry giving its match condition,
// next state on match / on dwell timeout, output value and dwell limit.
module fsm_programmable #(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 4,
    parameter int NUM_STATES = 8,
    parameter int TIMEOUT_W  = 8,
    localparam int STATE_W   = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync_clr,
    input  logic [IN_WIDTH-1:0]  in_signal,
    input  logic                 cfg_we,
    input  logic [STATE_W-1:0]   cfg_addr,
    input  logic [IN_WIDTH-1:0]  cfg_mask,
    input  logic [IN_WIDTH-1:0]  cfg_value,
    input  logic [STATE_W-1:0]   cfg_next_t,
    input  logic [STATE_W-1:0]   cfg_next_f,
    input  logic [OUT_WIDTH-1:0] cfg_out,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    output logic [OUT_WIDTH-1:0] out_signal,
    output logic [STATE_W-1:0]   state_o,
    output logic [TIMEOUT_W-1:0] dwell_o,
    output logic                 timeout_o,
    output logic                 err_o
);

    localparam logic [STATE_W:0] NS_LIM = (STATE_W+1)'(NUM_STATES);

    typedef struct packed {
        logic [IN_WIDTH-1:0]  mask;
        logic [IN_WIDTH-1:0]  value;
        logic [STATE_W-1:0]   next_t;
        logic [STATE_W-1:0]   next_f;
        logic [OUT_WIDTH-1:0] out;
        logic [TIMEOUT_W-1:0] timeout;
    } entry_t;

    entry_t               r_tbl [NUM_STATES];
    logic [STATE_W-1:0]   r_state;
    logic [TIMEOUT_W-1:0] r_dwell;
    logic                 r_tmo;
    logic                 r_err;

    entry_t               w_cur;
    logic                 w_cond;
    logic                 w_tmo_hit;
    logic                 w_addr_ok;
    logic                 w_take;
    logic [STATE_W-1:0]   w_target;
    logic [STATE_W-1:0]   w_state_nxt;
    logic [TIMEOUT_W-1:0] w_dwell_nxt;
    logic                 w_tmo_nxt;
    logic                 w_err_nxt;

    assign w_cur     = r_tbl[r_state];
    assign w_cond    = ((in_signal & w_cur.mask) == (w_cur.value & w_cur.mask));
    // A zero limit leaves the state on the first non-matching enabled cycle.
    assign w_tmo_hit = (w_cur.timeout == '0) ||
                       (r_dwell == (w_cur.timeout - TIMEOUT_W'(1)));
    assign w_addr_ok = ({1'b0, cfg_addr} < NS_LIM);

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_tmo_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_take      = 1'b0;
        w_target    = w_cur.next_t;
        if (sync_clr) begin
            w_state_nxt = '0;
            w_dwell_nxt = '0;
        end else if (en) begin
            if (w_cond) begin
                w_take   = 1'b1;
                w_target = w_cur.next_t;
            end else if (w_tmo_hit) begin
                w_take    = 1'b1;
                w_target  = w_cur.next_f;
                w_tmo_nxt = 1'b1;
            end else if (r_dwell != '1) begin
                w_dwell_nxt = r_dwell + TIMEOUT_W'(1);
            end
            if (w_take) begin
                w_dwell_nxt = '0;
                // Out-of-range targets recover to state 0 and report an error instead.
                if ({1'b0, w_target} >= NS_LIM) begin
                    w_state_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_tmo_nxt   = 1'b0;
                end else begin
                    w_state_nxt = w_target;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_dwell <= '0;
            r_tmo   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Default table is a plain ring 0 -> 1 -> ... -> N-1 -> 0 with out = index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                r_tbl[i].mask    <= '0;
                r_tbl[i].value   <= '0;
                r_tbl[i].next_t  <= STATE_W'((i + 1) % NUM_STATES);
                r_tbl[i].next_f  <= STATE_W'((i + 1) % NUM_STATES);
                r_tbl[i].out     <= OUT_WIDTH'(i);
                r_tbl[i].timeout <= '0;
            end
        end else if (cfg_we && w_addr_ok) begin
            r_tbl[cfg_addr].mask    <= cfg_mask;
            r_tbl[cfg_addr].value   <= cfg_value;
            r_tbl[cfg_addr].next_t  <= cfg_next_t;
            r_tbl[cfg_addr].next_f  <= cfg_next_f;
            r_tbl[cfg_addr].out     <= cfg_out;
            r_tbl[cfg_addr].timeout <= cfg_timeout;
        end
    end

    assign out_signal = w_cur.out;
    assign state_o    = r_state;
    assign dwell_o    = r_dwell;
    assign timeout_o  = r_tmo;
    assign err_o      = r_err;

endmodule
